cordic_phase_frontend: RTL and testbench

- Sits directly upstream and downstream of the iterative CORDIC sin/cos core. The core's inputs and outputs are signed Q2.14 (FRAC_BITS = 14), and its convergence range covers only about ±π/2.
- The block accepts a full-turn unsigned phase word over a valid/ready handshake and folds it into [-π/2, π/2). It converts the folded phase to Q2.14 radians and drives the core's start/angle inputs.
- It waits on the core's busy signal, applies the quadrant sign fix to sin/cos, and presents the result over a valid/ready handshake.

---
 rtl/cordic_pkg.sv | 24 ++
 rtl/cordic_phase_fold.sv | 23 ++
 rtl/cordic_phase_frontend.sv | 149 ++++++++++++++
 tb/tb_cordic_phase_frontend.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared types, constants and helpers for the CORDIC phase front end
package cordic_pkg;

  typedef logic signed [15:0] fixed_t;

  localparam int          FRAC_BITS = 14;
  localparam logic [16:0] PI_Q      = 17'd51472;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    ISSUE,
    ARM,
    RUN,
    HOLD
  } state_t;

  // -(-32768) has no Q2.14 encoding, so it clamps to the largest positive value
  function automatic fixed_t sat_neg(input fixed_t x);
    if (x == 16'sh8000) return 16'sh7fff;
    return -x;
  endfunction

endpackage

// File: rtl/cordic_phase_fold.sv
// rtl/cordic_phase_fold.sv - folds a full-turn phase into [-pi/2, pi/2) and scales it to Q2.14 radians
module cordic_phase_fold
  import cordic_pkg::*;
(
  input  logic [15:0] phase,
  output logic [15:0] angle,
  output logic        neg
);

  localparam logic signed [32:0] ROUND = 33'sd1 <<< FRAC_BITS;

  fixed_t             folded;
  logic signed [32:0] prod;

  // Flipping the MSB shifts the phase by pi; the result sign is restored downstream.
  always_comb begin
    neg    = phase[15] ^ phase[14];
    folded = neg ? fixed_t'(phase ^ 16'h8000) : fixed_t'(phase);
    prod   = $signed({{17{folded[15]}}, folded}) * $signed({16'd0, PI_Q});
    angle  = 16'((prod + ROUND) >>> (FRAC_BITS + 1));
  end

endmodule

// File: rtl/cordic_phase_frontend.sv
// rtl/cordic_phase_frontend.sv - phase request front end that drives the CORDIC core and sign-fixes its result
module cordic_phase_frontend
  import cordic_pkg::*;
#(
  parameter int PHASE_W     = 16,
  parameter int ARM_TIMEOUT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PHASE_W-1:0] phase_in,
  output logic               core_start,
  output logic [15:0]        core_angle,
  input  logic               core_busy,
  input  logic [15:0]        core_sin,
  input  logic [15:0]        core_cos,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        sin_out,
  output logic [15:0]        cos_out,
  output logic               err
);

  localparam int               CNT_W    = $clog2(ARM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [15:0]      phase_q, phase_d;
  logic [15:0]      angle_q, angle_d;
  logic             neg_q, neg_d;
  logic             start_q, start_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      sin_q, sin_d;
  logic [15:0]      cos_q, cos_d;

  logic [15:0]      fold_angle;
  logic             fold_neg;

  cordic_phase_fold u_fold (
    .phase (phase_q),
    .angle (fold_angle),
    .neg   (fold_neg)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    angle_d     = angle_q;
    neg_d       = neg_q;
    start_d     = 1'b0;
    cnt_d       = cnt_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    sin_d       = sin_q;
    cos_d       = cos_q;

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_ready_q && in_valid) begin
          phase_d    = 16'(phase_in);
          in_ready_d = 1'b0;
          state_d    = CONV;
        end
      end
      CONV: begin
        angle_d = fold_angle;
        neg_d   = fold_neg;
        start_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = ARM;
      end
      // A core that never raises busy is treated as single-cycle, so the result is still delivered.
      ARM: begin
        if (core_busy) begin
          state_d = RUN;
        end else if (cnt_q == ARM_LAST) begin
          err_d   = 1'b1;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!core_busy) begin
          sin_d       = neg_q ? sat_neg(core_sin) : core_sin;
          cos_d       = neg_q ? sat_neg(core_cos) : core_cos;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      angle_q     <= '0;
      neg_q       <= 1'b0;
      start_q     <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sin_q       <= '0;
      cos_q       <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      angle_q     <= angle_d;
      neg_q       <= neg_d;
      start_q     <= start_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sin_q       <= sin_d;
      cos_q       <= cos_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign core_start = start_q;
  assign core_angle = angle_q;
  assign out_valid  = out_valid_q;
  assign sin_out    = sin_q;
  assign cos_out    = cos_q;
  assign err        = err_q;

endmodule

// File: tb/tb_cordic_phase_frontend.sv
// tb/tb_cordic_phase_frontend.sv - scoreboard bench for cordic_phase_frontend with a behavioural CORDIC core
module tb_cordic_phase_frontend;

  localparam int    BUSY_CYCLES = 8;
  localparam int    ARM_TO      = 4;
  localparam int    M_NORM      = 0;
  localparam int    M_FORCE     = 1;
  localparam int    M_NOBUSY    = 2;
  localparam real   TWO_PI      = 6.283185307179586;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] phase_in;
  logic        core_start;
  logic [15:0] core_angle;
  logic        core_busy;
  logic [15:0] core_sin;
  logic [15:0] core_cos;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sin_out;
  logic [15:0] cos_out;
  logic        err;

  cordic_phase_frontend #(.PHASE_W(16), .ARM_TIMEOUT(ARM_TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .phase_in   (phase_in),
    .core_start (core_start),
    .core_angle (core_angle),
    .core_busy  (core_busy),
    .core_sin   (core_sin),
    .core_cos   (core_cos),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sin_out    (sin_out),
    .cos_out    (cos_out),
    .err        (err)
  );

  typedef struct {
    int sin_v;
    int cos_v;
    int tol;
    int lat;
    int acc;
    int err_v;
  } exp_t;

  exp_t res_q[$];
  int   ang_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   core_mode = M_NORM;
  int   model_err = 0;
  bit   rand_ready = 0;
  bit   seen_valid = 0;
  int   valid_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp_v, input int tol);
    int d;
    checks++;
    d = act - exp_v;
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp_v, tol);
    end
  endtask

  function automatic int rnd(input real x);
    return $rtoi($floor(x + 0.5));
  endfunction

  // Phases in [pi/2, 3pi/2) are the ones the front end must fold.
  function automatic bit ref_neg(input int ph);
    return (ph >= 16384) && (ph < 49152);
  endfunction

  function automatic int ref_angle(input int ph);
    int pf;
    pf = (ph >= 32768) ? ph - 65536 : ph;
    if (ref_neg(ph)) pf = (pf >= 0) ? pf - 32768 : pf + 32768;
    return $rtoi($floor((pf * 51472.0 + 16384.0) / 32768.0));
  endfunction

  // Behavioural core: ideal sin/cos of the Q2.14 angle, busy for BUSY_CYCLES.
  int  pend_s, pend_c, busy_cnt;
  real ca;
  int  cs, cc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_busy <= 1'b0;
      core_sin  <= '0;
      core_cos  <= '0;
      busy_cnt  <= 0;
    end else if (core_start) begin
      ca = $itor($signed(core_angle)) / 16384.0;
      cs = rnd(16384.0 * $sin(ca));
      cc = rnd(16384.0 * $cos(ca));
      if (core_mode == M_FORCE) begin
        cs = -32768;
        cc = 4660;
      end
      if (core_mode == M_NOBUSY) begin
        core_sin <= 16'(cs);
        core_cos <= 16'(cc);
      end else begin
        core_busy <= 1'b1;
        busy_cnt  <= BUSY_CYCLES;
        pend_s    <= cs;
        pend_c    <= cc;
      end
    end else if (core_busy) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) begin
        core_busy <= 1'b0;
        core_sin  <= 16'(pend_s);
        core_cos  <= 16'(pend_c);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Scoreboard: push on accepted requests, compare on core starts and result transfers.
  exp_t mon_e;
  real  th;
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        th = TWO_PI * $itor(phase_in) / 65536.0;
        ang_q.push_back(ref_angle(int'(phase_in)));
        if (core_mode == M_FORCE) begin
          mon_e.sin_v = ref_neg(int'(phase_in)) ? 32767 : -32768;
          mon_e.cos_v = ref_neg(int'(phase_in)) ? -4660 : 4660;
          mon_e.tol   = 0;
        end else begin
          mon_e.sin_v = rnd(16384.0 * $sin(th));
          mon_e.cos_v = rnd(16384.0 * $cos(th));
          mon_e.tol   = 2;
        end
        if (core_mode == M_NOBUSY) begin
          model_err = 1;
          mon_e.lat = 4 + ARM_TO;
        end else begin
          mon_e.lat = 4 + BUSY_CYCLES;
        end
        mon_e.err_v = model_err;
        mon_e.acc   = cyc;
        res_q.push_back(mon_e);
      end
      if (core_start) begin
        if (ang_q.size() == 0) chk("spurious_core_start", 1, 0, 0);
        else chk("core_angle", int'($signed(core_angle)), ang_q.pop_front(), 0);
      end
      if (out_valid && !seen_valid) begin
        seen_valid = 1;
        valid_cyc  = cyc;
      end
      if (out_valid && out_ready) begin
        if (res_q.size() == 0) begin
          chk("unexpected_result", 1, 0, 0);
        end else begin
          mon_e = res_q.pop_front();
          chk("sin_out", int'($signed(sin_out)), mon_e.sin_v, mon_e.tol);
          chk("cos_out", int'($signed(cos_out)), mon_e.cos_v, mon_e.tol);
          chk("latency", valid_cyc - mon_e.acc, mon_e.lat, 0);
          chk("err_at_result", int'(err), mon_e.err_v, 0);
        end
        seen_valid = 0;
      end
    end
  end

  task automatic wait_accept();
    int n;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    if (n >= 100) chk("accept_timeout", 0, 1, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drive_req(input logic [15:0] ph);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    phase_in = ph;
    wait_accept();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (res_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (res_q.size() != 0) chk("drain_timeout", res_q.size(), 0, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0, 0);
    chk({tag, "_core_start"}, int'(core_start), 0, 0);
    chk({tag, "_core_angle"}, int'(core_angle), 0, 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0, 0);
    chk({tag, "_sin_out"}, int'(sin_out), 0, 0);
    chk({tag, "_cos_out"}, int'(cos_out), 0, 0);
    chk({tag, "_err"}, int'(err), 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] hold_s, hold_c;
  int          n;

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    phase_in  = '0;
    out_ready = 1'b1;
    #1 rst_n  = 1'b0;
    #1 chk_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_in_ready", int'(in_ready), 1, 0);

    foreach (ang_q[i]) ang_q[i] = 0;
    drive_req(16'h0000);
    drive_req(16'h2000);
    drive_req(16'h4000);
    drive_req(16'h8000);
    drive_req(16'hE000);
    drive_req(16'hBFFF);
    drive_req(16'hC000);
    wait_drain();

    rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      drive_req(16'($urandom));
    end
    wait_drain();
    rand_ready = 0;
    out_ready  = 1'b1;
    chk("err_clear_normal", int'(err), 0, 0);

    core_mode = M_FORCE;
    drive_req(16'h8000);
    drive_req(16'h0000);
    drive_req(16'hC123);
    wait_drain();
    core_mode = M_NORM;

    out_ready = 1'b0;
    drive_req(16'h2000);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid_seen", int'(out_valid), 1, 0);
    hold_s = sin_out;
    hold_c = cos_out;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    phase_in = 16'h6000;
    repeat (5) begin
      @(negedge clk);
      chk("stall_out_valid", int'(out_valid), 1, 0);
      chk("stall_in_ready", int'(in_ready), 0, 0);
      chk("stall_sin_stable", int'(sin_out), int'(hold_s), 0);
      chk("stall_cos_stable", int'(cos_out), int'(hold_c), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_accept();
    wait_drain();

    core_mode = M_NOBUSY;
    drive_req(16'h1000);
    drive_req(16'h9000);
    wait_drain();
    chk("err_sticky", int'(err), 1, 0);
    core_mode = M_NORM;

    drive_req(16'h5000);
    n = 0;
    while (!core_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("busy_before_reset", int'(core_busy), 1, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset_outputs("midrun");
    res_q.delete();
    ang_q.delete();
    seen_valid = 0;
    model_err  = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_in_ready", int'(in_ready), 1, 0);
    chk("post_reset_out_valid", int'(out_valid), 0, 0);
    drive_req(16'h3000);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
